sys_cmd_decoder: RTL and testbench

- Parametrised successor to the receive-side system controller.
- Decodes byte frames from the UART receiver into register-file write/read, ALU operation, and new burst-write commands.
- Drives the ALU enable/function, register-file port and ALU clock-gate enable.
- Adds a frame-timeout abort, error reporting, a busy flag and a configurable ALU settle time.

---
 rtl/sys_cntr_pkg.sv | 24 ++
 rtl/sys_frame_timer.sv | 30 +++
 rtl/sys_cmd_decoder.sv | 187 ++++++++++++++++++
 tb/tb_sys_cmd_decoder.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_cntr_pkg.sv
// Opcodes and FSM state encoding shared by the system command controllers.
package sys_cntr_pkg;

    localparam logic [7:0] CMD_WR     = 8'hAA;
    localparam logic [7:0] CMD_RD     = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP = 8'hCC;
    localparam logic [7:0] CMD_ALU    = 8'hDD;
    localparam logic [7:0] CMD_BURST  = 8'hEE;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_OP_A,
        ST_OP_B,
        ST_FUN,
        ST_ALU_HOLD,
        ST_BW_CNT,
        ST_BW_ADDR,
        ST_BW_DATA
    } state_e;

endpackage

// File: rtl/sys_frame_timer.sv
// Inter-byte watchdog: reloads on clear, counts down while enabled and
// pulses expire_c for one cycle after TIMEOUT enabled cycles without a clear.
module sys_frame_timer #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic CLK,
    input  logic Reset,
    input  logic clr,
    input  logic en,
    output logic expire_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    assign expire_c = en && !clr && (cnt == '0);

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            cnt <= LOAD_VAL;
        end else if (clr || expire_c) begin
            cnt <= LOAD_VAL;
        end else if (en) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/sys_cmd_decoder.sv
// Receive-side system controller: turns UART byte frames into register-file,
// ALU and burst-write strobes, with frame timeout and error reporting.
module sys_cmd_decoder
    import sys_cntr_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned FUN_W    = 4,
    parameter int unsigned OP_BASE  = 0,
    parameter int unsigned ALU_WAIT = 2,
    parameter int unsigned TIMEOUT  = 1024,
    localparam int unsigned ADDR_W  = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [WIDTH-1:0]  Rx_P_Data,
    input  logic              RxValid,
    output logic              ALU_EN,
    output logic [FUN_W-1:0]  ALU_FUN,
    output logic [ADDR_W-1:0] Reg_File_Address,
    output logic              WrEN,
    output logic              RdEN,
    output logic [WIDTH-1:0]  WrData,
    output logic              CLK_GATE_EN,
    output logic              Frame_Err,
    output logic              Busy
);

    localparam int unsigned HOLD_W = $clog2(ALU_WAIT + 1);
    localparam logic [ADDR_W-1:0] OP_A_ADDR = ADDR_W'(OP_BASE % DEPTH);
    localparam logic [ADDR_W-1:0] OP_B_ADDR = ADDR_W'((OP_BASE + 1) % DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e            state;
    logic [ADDR_W-1:0] frame_addr;
    logic [WIDTH-1:0]  bw_left;
    logic [HOLD_W-1:0] hold_cnt;
    logic              timer_en_c;
    logic              timer_clr_c;
    logic              timeout_c;
    logic [7:0]        opcode_c;
    logic [ADDR_W-1:0] rx_addr_c;
    logic [ADDR_W-1:0] next_addr_c;

    assign opcode_c    = Rx_P_Data[7:0];
    assign rx_addr_c   = Rx_P_Data[ADDR_W-1:0];
    assign next_addr_c = (frame_addr == LAST_ADDR) ? '0 : frame_addr + ADDR_W'(1);

    // Watchdog runs only while waiting for the next byte of a frame.
    assign timer_en_c  = (state != ST_IDLE) && (state != ST_ALU_HOLD);
    assign timer_clr_c = RxValid || !timer_en_c;

    sys_frame_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_frame_timer (
        .CLK      (CLK),
        .Reset    (Reset),
        .clr      (timer_clr_c),
        .en       (timer_en_c),
        .expire_c (timeout_c)
    );

    // ALU_HOLD covers the ALU_EN cycle plus ALU_WAIT further gated cycles.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state            <= ST_IDLE;
            frame_addr       <= '0;
            bw_left          <= '0;
            hold_cnt         <= '0;
            ALU_EN           <= 1'b0;
            ALU_FUN          <= '0;
            Reg_File_Address <= '0;
            WrEN             <= 1'b0;
            RdEN             <= 1'b0;
            WrData           <= '0;
            CLK_GATE_EN      <= 1'b0;
            Frame_Err        <= 1'b0;
            Busy             <= 1'b0;
        end else begin
            ALU_EN    <= 1'b0;
            WrEN      <= 1'b0;
            RdEN      <= 1'b0;
            Frame_Err <= 1'b0;
            if (timeout_c) begin
                state       <= ST_IDLE;
                Busy        <= 1'b0;
                CLK_GATE_EN <= 1'b0;
                Frame_Err   <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: if (RxValid) begin
                        Busy <= 1'b1;
                        case (opcode_c)
                            CMD_WR:     state <= ST_WR_ADDR;
                            CMD_RD:     state <= ST_RD_ADDR;
                            CMD_ALU_OP: begin state <= ST_OP_A; CLK_GATE_EN <= 1'b1; end
                            CMD_ALU:    begin state <= ST_FUN;  CLK_GATE_EN <= 1'b1; end
                            CMD_BURST:  state <= ST_BW_CNT;
                            default: begin
                                Busy      <= 1'b0;
                                Frame_Err <= 1'b1;
                            end
                        endcase
                    end
                    ST_WR_ADDR: if (RxValid) begin
                        frame_addr <= rx_addr_c;
                        state      <= ST_WR_DATA;
                    end
                    ST_WR_DATA: if (RxValid) begin
                        WrEN             <= 1'b1;
                        Reg_File_Address <= frame_addr;
                        WrData           <= Rx_P_Data;
                        state            <= ST_IDLE;
                        Busy             <= 1'b0;
                    end
                    ST_RD_ADDR: if (RxValid) begin
                        RdEN             <= 1'b1;
                        Reg_File_Address <= rx_addr_c;
                        state            <= ST_IDLE;
                        Busy             <= 1'b0;
                    end
                    ST_OP_A: if (RxValid) begin
                        WrEN             <= 1'b1;
                        Reg_File_Address <= OP_A_ADDR;
                        WrData           <= Rx_P_Data;
                        state            <= ST_OP_B;
                    end
                    ST_OP_B: if (RxValid) begin
                        WrEN             <= 1'b1;
                        Reg_File_Address <= OP_B_ADDR;
                        WrData           <= Rx_P_Data;
                        state            <= ST_FUN;
                    end
                    ST_FUN: if (RxValid) begin
                        ALU_EN   <= 1'b1;
                        ALU_FUN  <= Rx_P_Data[FUN_W-1:0];
                        hold_cnt <= HOLD_W'(ALU_WAIT);
                        state    <= ST_ALU_HOLD;
                    end
                    ST_ALU_HOLD: begin
                        if (RxValid) begin
                            Frame_Err <= 1'b1;
                        end
                        if (hold_cnt == '0) begin
                            state       <= ST_IDLE;
                            Busy        <= 1'b0;
                            CLK_GATE_EN <= 1'b0;
                        end else begin
                            hold_cnt <= hold_cnt - HOLD_W'(1);
                        end
                    end
                    ST_BW_CNT: if (RxValid) begin
                        if (Rx_P_Data == '0) begin
                            Frame_Err <= 1'b1;
                            state     <= ST_IDLE;
                            Busy      <= 1'b0;
                        end else begin
                            bw_left <= Rx_P_Data;
                            state   <= ST_BW_ADDR;
                        end
                    end
                    ST_BW_ADDR: if (RxValid) begin
                        frame_addr <= rx_addr_c;
                        state      <= ST_BW_DATA;
                    end
                    ST_BW_DATA: if (RxValid) begin
                        WrEN             <= 1'b1;
                        Reg_File_Address <= frame_addr;
                        WrData           <= Rx_P_Data;
                        frame_addr       <= next_addr_c;
                        bw_left          <= bw_left - WIDTH'(1);
                        if (bw_left == WIDTH'(1)) begin
                            state <= ST_IDLE;
                            Busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state       <= ST_IDLE;
                        Busy        <= 1'b0;
                        CLK_GATE_EN <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sys_cmd_decoder.sv
// Scoreboard bench for sys_cmd_decoder: frame-level model queues expected
// strobes and Busy/CLK_GATE_EN windows; a negedge monitor pops and compares.
module tb_sys_cmd_decoder;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned DEPTH    = 16;
    localparam int unsigned FUN_W    = 4;
    localparam int unsigned OP_BASE  = 0;
    localparam int unsigned ALU_WAIT = 2;
    localparam int unsigned TIMEOUT  = 1024;
    localparam int unsigned ADDR_W   = $clog2(DEPTH);

    localparam int K_WR  = 0;
    localparam int K_RD  = 1;
    localparam int K_ALU = 2;
    localparam int K_ERR = 3;

    typedef struct { int kind; int cyc; int addr; int data; } ev_t;
    typedef struct { int rise; int fall; } win_t;

    logic              CLK = 1'b0;
    logic              Reset;
    logic [WIDTH-1:0]  Rx_P_Data;
    logic              RxValid;
    logic              ALU_EN;
    logic [FUN_W-1:0]  ALU_FUN;
    logic [ADDR_W-1:0] Reg_File_Address;
    logic              WrEN;
    logic              RdEN;
    logic [WIDTH-1:0]  WrData;
    logic              CLK_GATE_EN;
    logic              Frame_Err;
    logic              Busy;

    ev_t  ev_q[$];
    win_t gate_q[$];
    win_t busy_q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   gmin = 0;
    int   gmax = 3;
    logic g_prev = 1'b0;
    logic b_prev = 1'b0;
    int   g_rise = 0;
    int   b_rise = 0;

    sys_cmd_decoder #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .FUN_W    (FUN_W),
        .OP_BASE  (OP_BASE),
        .ALU_WAIT (ALU_WAIT),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .CLK              (CLK),
        .Reset            (Reset),
        .Rx_P_Data        (Rx_P_Data),
        .RxValid          (RxValid),
        .ALU_EN           (ALU_EN),
        .ALU_FUN          (ALU_FUN),
        .Reg_File_Address (Reg_File_Address),
        .WrEN             (WrEN),
        .RdEN             (RdEN),
        .WrData           (WrData),
        .CLK_GATE_EN      (CLK_GATE_EN),
        .Frame_Err        (Frame_Err),
        .Busy             (Busy)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic void chk(string nm, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic void push_ev(int kind, int c, int addr, int data);
        ev_t e;
        e.kind = kind; e.cyc = c; e.addr = addr; e.data = data;
        ev_q.push_back(e);
    endfunction

    function automatic void push_win(bit gate, int rise, int fall);
        win_t w;
        w.rise = rise; w.fall = fall;
        if (gate) gate_q.push_back(w);
        else      busy_q.push_back(w);
    endfunction

    function automatic int gp();
        return $urandom_range(gmax, gmin);
    endfunction

    // Monitor: compare each presented strobe against the oldest expectation.
    task automatic take(int kind);
        ev_t e;
        if (ev_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_strobe: got kind %0d at cycle %0d, expected none", kind, cyc);
            return;
        end
        e = ev_q.pop_front();
        chk("strobe_kind", kind, e.kind);
        chk("strobe_cycle", cyc, e.cyc);
        if (kind == K_WR) begin
            chk("wr_addr", int'(Reg_File_Address), e.addr);
            chk("wr_data", int'(WrData), e.data);
        end
        if (kind == K_RD)  chk("rd_addr", int'(Reg_File_Address), e.addr);
        if (kind == K_ALU) chk("alu_fun", int'(ALU_FUN), e.data);
    endtask

    initial begin : monitor
        win_t w;
        forever begin
            @(negedge CLK);
            if (WrEN)      take(K_WR);
            if (RdEN)      take(K_RD);
            if (ALU_EN)    take(K_ALU);
            if (Frame_Err) take(K_ERR);
            if (CLK_GATE_EN && !g_prev) g_rise = cyc;
            if (!CLK_GATE_EN && g_prev) begin
                if (gate_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL gate_window: got unexpected fall at cycle %0d, expected none", cyc);
                end else begin
                    w = gate_q.pop_front();
                    chk("gate_rise", g_rise, w.rise);
                    chk("gate_fall", cyc, w.fall);
                end
            end
            if (Busy && !b_prev) b_rise = cyc;
            if (!Busy && b_prev) begin
                if (busy_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL busy_window: got unexpected fall at cycle %0d, expected none", cyc);
                end else begin
                    w = busy_q.pop_front();
                    chk("busy_rise", b_rise, w.rise);
                    chk("busy_fall", cyc, w.fall);
                end
            end
            g_prev = CLK_GATE_EN;
            b_prev = Busy;
        end
    end

    initial begin : watchdog
        repeat (60000) @(posedge CLK);
        $display("FAIL watchdog: got no end of test, expected finish within 60000 cycles");
        $fatal(1, "watchdog expired");
    end

    task automatic idle();
        @(posedge CLK); #1;
    endtask

    task automatic put(input int b, input int gap, output int n);
        repeat (gap) idle();
        Rx_P_Data = WIDTH'(b);
        RxValid   = 1'b1;
        n         = cyc;
        idle();
        RxValid   = 1'b0;
        Rx_P_Data = WIDTH'($urandom);
    endtask

    // Frame-level reference: each strobe lands the cycle after its byte.
    task automatic f_write(int a, int d);
        int n0, n1, n2;
        put('hAA, gp(), n0); put(a, gp(), n1); put(d, gp(), n2);
        push_ev(K_WR, n2 + 1, a % DEPTH, d);
        push_win(0, n0 + 1, n2 + 1);
    endtask

    task automatic f_read(int a);
        int n0, n1;
        put('hBB, gp(), n0); put(a, gp(), n1);
        push_ev(K_RD, n1 + 1, a % DEPTH, 0);
        push_win(0, n0 + 1, n1 + 1);
    endtask

    task automatic f_alu(bit ops, int a, int b, int fun, bit err);
        int n0, n1, nf, ne, endc;
        if (ops) begin
            put('hCC, gp(), n0);
            put(a, gp(), n1); push_ev(K_WR, n1 + 1, OP_BASE % DEPTH, a);
            put(b, gp(), n1); push_ev(K_WR, n1 + 1, (OP_BASE + 1) % DEPTH, b);
        end else begin
            put('hDD, gp(), n0);
        end
        put(fun, gp(), nf);
        push_ev(K_ALU, nf + 1, 0, fun % (1 << FUN_W));
        endc = nf + 2 + ALU_WAIT;
        if (err) begin
            put($urandom_range(255, 0), $urandom_range(ALU_WAIT, 0), ne);
            push_ev(K_ERR, ne + 1, 0, 0);
        end
        while (cyc < endc) idle();
        push_win(1, n0 + 1, endc);
        push_win(0, n0 + 1, endc);
    endtask

    task automatic f_burst(int n, int a, int d0);
        int n0, n1, nk;
        put('hEE, gp(), n0); put(n, gp(), n1);
        if (n == 0) begin
            push_ev(K_ERR, n1 + 1, 0, 0);
            push_win(0, n0 + 1, n1 + 1);
            return;
        end
        put(a, gp(), n1);
        for (int k = 0; k < n; k++) begin
            put((d0 + k * 'h11) % 256, gp(), nk);
            push_ev(K_WR, nk + 1, (a + k) % DEPTH, (d0 + k * 'h11) % 256);
        end
        push_win(0, n0 + 1, nk + 1);
    endtask

    task automatic f_bad(int b);
        int n0;
        put(b, gp(), n0);
        push_ev(K_ERR, n0 + 1, 0, 0);
    endtask

    task automatic f_timeout(int a);
        int n0, n1;
        put('hAA, gp(), n0); put(a, gp(), n1);
        push_ev(K_ERR, n1 + TIMEOUT + 1, 0, 0);
        push_win(0, n0 + 1, n1 + TIMEOUT + 1);
        while (cyc < n1 + TIMEOUT + 2) idle();
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, "_alu_en"}, int'(ALU_EN), 0);
        chk({tag, "_alu_fun"}, int'(ALU_FUN), 0);
        chk({tag, "_addr"}, int'(Reg_File_Address), 0);
        chk({tag, "_wren"}, int'(WrEN), 0);
        chk({tag, "_rden"}, int'(RdEN), 0);
        chk({tag, "_wrdata"}, int'(WrData), 0);
        chk({tag, "_gate"}, int'(CLK_GATE_EN), 0);
        chk({tag, "_ferr"}, int'(Frame_Err), 0);
        chk({tag, "_busy"}, int'(Busy), 0);
    endtask

    initial begin : stim
        int n0, n1, b, sel;
        Reset = 1'b1; RxValid = 1'b0; Rx_P_Data = '0;
        repeat (3) idle();
        chk_all_zero("reset");
        Reset = 1'b0;
        idle();

        gmin = 1; gmax = 1;
        f_write(5, 'h3C);
        gmin = 0; gmax = 2;
        f_alu(1, 'h12, 'h34, 'h02, 0);
        f_burst(3, 'h0F, 'h11);
        f_burst(0, 0, 0);
        f_timeout('h07);
        f_read('h07);
        f_bad('h55);
        f_alu(0, 0, 0, 'h09, 1);

        // Asynchronous reset mid-frame discards it without an error pulse.
        put('hCC, 0, n0); put('h12, 0, n1);
        push_ev(K_WR, n1 + 1, OP_BASE % DEPTH, 'h12);
        idle();
        push_win(1, n0 + 1, cyc);
        push_win(0, n0 + 1, cyc);
        Reset = 1'b1;
        #1;
        chk_all_zero("async_reset");
        idle(); idle();
        Reset = 1'b0;
        idle();
        f_alu(0, 0, 0, 'h05, 0);

        gmin = 0; gmax = 3;
        for (int i = 0; i < 80; i++) begin
            sel = $urandom_range(7, 0);
            case (sel)
                0: f_write($urandom_range(255, 0), $urandom_range(255, 0));
                1: f_read($urandom_range(255, 0));
                2: f_alu(1, $urandom_range(255, 0), $urandom_range(255, 0), $urandom_range(255, 0), 0);
                3: f_alu(0, 0, 0, $urandom_range(255, 0), $urandom_range(1, 0) == 1);
                4: f_burst($urandom_range(6, 1), $urandom_range(255, 0), $urandom_range(255, 0));
                5: f_burst(0, 0, 0);
                6: f_alu(1, $urandom_range(255, 0), $urandom_range(255, 0), $urandom_range(255, 0), 1);
                default: begin
                    do b = $urandom_range(255, 0);
                    while (b == 'hAA || b == 'hBB || b == 'hCC || b == 'hDD || b == 'hEE);
                    f_bad(b);
                end
            endcase
        end

        repeat (8) idle();
        chk("ev_queue_drained", ev_q.size(), 0);
        chk("gate_queue_drained", gate_q.size(), 0);
        chk("busy_queue_drained", busy_q.size(), 0);
        chk("idle_busy", int'(Busy), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
